ripple_count_monitor: RTL and testbench

Synchronous monitor that sits directly downstream of the 4-bit ripple carry counter. It captures the counter's rippled output into the `clk` domain and checks that each step is a +1 increment. It produces match and wrap-around event pulses, keeps a saturating wrap count, and detects stalls and illegal steps. All outputs are registered and safe for any downstream synchronous logic.

---
 rtl/ripple_count_monitor.sv | 118 +++++++++++
 tb/tb_ripple_count_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor.sv
// Purpose : samples a free-running ripple counter into clk and checks each step is +1 (match/wrap/stall/error).
// Latency : cnt_sync one edge after sampling; pulses, counters and flags one edge after that.
// Backpr. : none; this is a passive monitor that accepts one sample every clk edge.
module ripple_count_monitor #(
    parameter int WIDTH     = 4,
    parameter int WRAP_W    = 8,
    parameter int STALL_LIM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic [WIDTH-1:0]  match_val,
    input  logic              match_en,
    input  logic              clear,
    output logic [WIDTH-1:0]  cnt_sync,
    output logic              match_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              step_err,
    output logic              err_sticky,
    output logic              stalled
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Stall run counter is 8 bits wide because the limit may be as large as 255.
    localparam logic [7:0] STALL_MAX = 8'(STALL_LIM);

    state_t              state;
    logic [1:0]          prime;
    logic [WIDTH-1:0]    smp;
    logic [WIDTH-1:0]    prev;
    logic [7:0]          stall_run;

    logic [WIDTH-1:0]    delta;
    logic                is_hold;
    logic                is_step;
    logic                is_illegal;
    logic                is_wrap;
    logic                is_match;
    logic [7:0]          stall_run_nxt;
    logic [WRAP_W-1:0]   wrap_count_nxt;

    assign cnt_sync = smp;

    // Classify the step between the last two samples and precompute saturating counter updates.
    always_comb begin
        delta          = smp - prev;
        is_hold        = (delta == '0);
        is_step        = (delta == WIDTH'(1));
        is_illegal     = !is_hold && !is_step;
        is_wrap        = (prev == '1) && (smp == '0);
        is_match       = match_en && (smp == match_val);
        stall_run_nxt  = 8'd0;
        if (is_hold) begin
            stall_run_nxt = (stall_run == STALL_MAX) ? stall_run : stall_run + 8'd1;
        end
        wrap_count_nxt = wrap_count;
        if (is_wrap && (wrap_count != '1)) begin
            wrap_count_nxt = wrap_count + WRAP_W'(1);
        end
    end

    // Sampling pipeline, INIT/RUN/FAULT state machine and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT;
            prime       <= 2'd0;
            smp         <= '0;
            prev        <= '0;
            stall_run   <= 8'd0;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            step_err    <= 1'b0;
            err_sticky  <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            prev <= smp;
            smp  <= cnt_in;
            if (state == ST_INIT) begin
                // smp and prev hold real samples only from the second edge on.
                prime       <= prime + 2'd1;
                match_pulse <= 1'b0;
                wrap_pulse  <= 1'b0;
                step_err    <= 1'b0;
                if (prime == 2'd1) begin
                    state <= ST_RUN;
                end
            end else begin
                // Pulses are driven even on a clearing edge; only the state they would leave behind is dropped.
                match_pulse <= is_match;
                wrap_pulse  <= is_wrap;
                step_err    <= is_illegal;
                if (clear) begin
                    state      <= ST_RUN;
                    wrap_count <= '0;
                    stall_run  <= 8'd0;
                    stalled    <= 1'b0;
                    err_sticky <= 1'b0;
                end else begin
                    wrap_count <= wrap_count_nxt;
                    stall_run  <= stall_run_nxt;
                    stalled    <= (stall_run_nxt == STALL_MAX);
                    if (is_illegal) begin
                        state      <= ST_FAULT;
                        err_sticky <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Purpose : directed self-checking bench for ripple_count_monitor, with a behavioural ripple counter source.
// Latency : checks outputs 1 time unit after each rising edge; inputs change on falling edges.
// Backpr. : none; the monitor takes a sample every cycle.
module tb_ripple_count_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt_in;
    logic [3:0] match_val = 4'd0;
    logic       match_en = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] cnt_sync;
    logic       match_pulse;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       step_err;
    logic       err_sticky;
    logic       stalled;

    logic [3:0] drv = 4'd0;
    logic       use_rc = 1'b0;
    logic       rc0, rc1, rc2, rc3;
    logic [3:0] rc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Ripple carry counter: bit 0 toggles on the falling clk edge, each higher bit on the fall of the one below.
    always @(negedge clk or posedge reset) if (reset) rc0 <= 1'b0; else rc0 <= ~rc0;
    always @(negedge rc0 or posedge reset) if (reset) rc1 <= 1'b0; else rc1 <= ~rc1;
    always @(negedge rc1 or posedge reset) if (reset) rc2 <= 1'b0; else rc2 <= ~rc2;
    always @(negedge rc2 or posedge reset) if (reset) rc3 <= 1'b0; else rc3 <= ~rc3;
    assign rc     = {rc3, rc2, rc1, rc0};
    assign cnt_in = use_rc ? rc : drv;

    ripple_count_monitor #(.WIDTH(4), .WRAP_W(8), .STALL_LIM(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_in      (cnt_in),
        .match_val   (match_val),
        .match_en    (match_en),
        .clear       (clear),
        .cnt_sync    (cnt_sync),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .step_err    (step_err),
        .err_sticky  (err_sticky),
        .stalled     (stalled)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one count value on the falling edge, then look just after the next rising edge.
    task automatic step(input logic [3:0] v);
        @(negedge clk);
        drv = v;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset released during clk high, so the next rising edge is edge 1 of priming.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        drv   = 4'd0;
        clear = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt_sync"}, 32'(cnt_sync), 0);
        chk({tag, "_match"},    32'(match_pulse), 0);
        chk({tag, "_wrap"},     32'(wrap_pulse), 0);
        chk({tag, "_wrapcnt"},  32'(wrap_count), 0);
        chk({tag, "_step_err"}, 32'(step_err), 0);
        chk({tag, "_sticky"},   32'(err_sticky), 0);
        chk({tag, "_stalled"},  32'(stalled), 0);
    endtask

    initial begin
        #1;
        chk_all_zero("rst");

        // Free-running ripple counter: at edge k the sample is k mod 16.
        use_rc    = 1'b1;
        match_val = 4'd9;
        match_en  = 1'b1;
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            tick();
            chk("fr_cnt_sync", 32'(cnt_sync), 32'(k % 16));
            chk("fr_wrap", 32'(wrap_pulse), 32'((k >= 3) && (k % 16 == 1)));
            chk("fr_match", 32'(match_pulse), 32'((k >= 3) && (k % 16 == 10)));
            chk("fr_step_err", 32'(step_err), 0);
        end
        chk("fr_wrap_count", 32'(wrap_count), 4);
        chk("fr_sticky", 32'(err_sticky), 0);

        match_en = 1'b0;
        for (int k = 71; k <= 102; k++) begin
            tick();
            chk("nomatch_pulse", 32'(match_pulse), 0);
            chk("nomatch_wrap", 32'(wrap_pulse), 32'(k % 16 == 1));
        end
        chk("nomatch_wrap_count", 32'(wrap_count), 6);

        // Reset mid-count: outputs clear without waiting for a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        use_rc = 1'b0;
        drv    = 4'd0;
        @(posedge clk);
        #2;
        reset     = 1'b0;
        match_val = 4'd9;
        match_en  = 1'b1;
        step(4'd9);
        chk("rp1_cnt_sync", 32'(cnt_sync), 9);
        chk("rp1_step_err", 32'(step_err), 0);
        step(4'd10);
        chk("rp2_step_err", 32'(step_err), 0);
        chk("rp2_match", 32'(match_pulse), 0);
        step(4'd11);
        chk("rp3_step_err", 32'(step_err), 0);
        match_val = 4'd12;
        step(4'd12);
        step(4'd13);
        chk("rp5_match", 32'(match_pulse), 1);
        step(4'd0);
        chk("rp6_match", 32'(match_pulse), 0);
        step(4'd1);
        chk("rp7_step_err", 32'(step_err), 1);
        chk("rp7_sticky", 32'(err_sticky), 1);

        // Illegal step 3 -> 7.
        match_en = 1'b0;
        do_reset();
        step(4'd1); step(4'd2); step(4'd3); step(4'd7);
        chk("ill_pre_err", 32'(step_err), 0);
        step(4'd8);
        chk("ill_err", 32'(step_err), 1);
        chk("ill_sticky", 32'(err_sticky), 1);
        step(4'd9);
        chk("ill_err_once", 32'(step_err), 0);
        chk("ill_sticky_hold", 32'(err_sticky), 1);
        step(4'd10);
        chk("ill_sticky_hold2", 32'(err_sticky), 1);
        clear = 1'b1;
        step(4'd11);
        clear = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 0);
        step(4'd12);
        chk("clr_err", 32'(step_err), 0);
        step(4'd2);
        // Error and clear on the same edge: pulse still driven, sticky stays low.
        clear = 1'b1;
        step(4'd3);
        clear = 1'b0;
        chk("clrpri_err", 32'(step_err), 1);
        chk("clrpri_sticky", 32'(err_sticky), 0);
        step(4'd4);
        step(4'd9);
        chk("run_ok_sticky", 32'(err_sticky), 0);
        step(4'd10);
        chk("run_err", 32'(step_err), 1);
        chk("run_err_sticky", 32'(err_sticky), 1);
        step(4'd1);
        chk("fault_ok_err", 32'(step_err), 0);
        step(4'd2);
        chk("fault_repulse", 32'(step_err), 1);
        chk("fault_sticky", 32'(err_sticky), 1);

        // Stall: hold 5 for ten cycles; the eighth zero-delta evaluation raises stalled.
        do_reset();
        step(4'd1); step(4'd2); step(4'd3); step(4'd4); step(4'd5);
        for (int i = 1; i <= 10; i++) begin
            step(4'd5);
            chk("stall_flag", 32'(stalled), 32'(i >= 9));
            chk("stall_err", 32'(step_err), 0);
        end
        step(4'd6);
        chk("stall_resume0", 32'(stalled), 1);
        step(4'd7);
        chk("stall_resume1", 32'(stalled), 0);
        chk("stall_resume_err", 32'(step_err), 0);

        // Saturation: 300 wraps leave the counter pinned at 255.
        do_reset();
        for (int i = 0; i < 4801; i++) begin
            step(drv + 4'd1);
        end
        chk("sat_wrap_count", 32'(wrap_count), 255);
        chk("sat_err", 32'(err_sticky), 0);
        while (drv != 4'd15) begin
            step(drv + 4'd1);
        end
        step(4'd0);
        chk("sat_hold", 32'(wrap_count), 255);
        chk("sat_nowrap", 32'(wrap_pulse), 0);
        clear = 1'b1;
        step(4'd1);
        clear = 1'b0;
        chk("clrwrap_pulse", 32'(wrap_pulse), 1);
        chk("clrwrap_count", 32'(wrap_count), 0);
        for (int i = 0; i < 16; i++) begin
            step(drv + 4'd1);
        end
        chk("after_clr_wrap", 32'(wrap_pulse), 1);
        chk("after_clr_count", 32'(wrap_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
